// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The FIFO entry is laid out {instr, pc} so its packed form is the decode-facing bus.
package instr_fetch_queue_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ENTRY_W = INSTR_W + PC_W;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Instruction-memory and decode-side signals of the fetch stage.
// master = fetch stage, slave = the memory/decode environment.
interface instr_fetch_queue_if
    import instr_fetch_queue_pkg::*;
();

    logic                 imem_req;
    logic [PC_W-1:0]      imem_addr;
    logic [INSTR_W-1:0]   imem_rdata;
    logic                 jaccept;
    logic [PC_W-1:0]      jaddr;
    logic                 decode_ready;
    logic                 fetch_valid;
    logic [ENTRY_W-1:0]   fetch_instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  jaccept,
        input  jaddr,
        input  decode_ready,
        output fetch_valid,
        output fetch_instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output jaccept,
        output jaddr,
        output decode_ready,
        input  fetch_valid,
        input  fetch_instr_pc
    );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// DEPTH-entry FIFO of fetch entries with synchronous flush.
// Flush wins over push and pop; head reads as all-zero while empty.
module instr_fetch_queue_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            push_en;
    logic            pop_en;

    always_comb begin
        push_en  = push && !flush;
        pop_en   = pop && (count_q != '0) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap for free since DEPTH is a power of two.
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PtrW{1'b0}}, push_en} - {{PtrW{1'b0}}, pop_en};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues credit-limited reads to a 1-cycle instruction
// memory and queues {instr, pc} for decode; a decode-accepted jump flushes and redirects.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic                 clk,
    input logic                 reset_n,
    instr_fetch_queue_if.master bus
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic            run_q;
    logic            req;
    logic            push;
    logic            pop;
    logic [CntW-1:0] count;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    always_comb begin
        // Entries held plus the response still in flight may never exceed DEPTH,
        // so a push can never find the FIFO full. run_q holds req low out of reset.
        req           = run_q && !bus.jaccept && ((32'(count) + 32'(inflight_q)) < DEPTH);
        pc_d          = pc_q;
        inflight_d    = req;
        inflight_pc_d = inflight_pc_q;
        if (bus.jaccept) begin
            pc_d = word_align(bus.jaddr);
        end else if (req) begin
            pc_d          = pc_q + 32'd4;
            inflight_pc_d = pc_q;
        end
    end

    // A redirect in the response cycle drops that response along with the flush.
    always_comb begin
        push            = inflight_q && !bus.jaccept;
        push_data.instr = bus.imem_rdata;
        push_data.pc    = inflight_pc_q;
        pop             = (count != '0) && bus.decode_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            run_q         <= 1'b1;
        end
    end

    instr_fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (bus.jaccept),
        .head      (head),
        .count     (count)
    );

    assign bus.imem_req       = req;
    assign bus.imem_addr      = pc_q;
    assign bus.fetch_valid    = (count != '0);
    assign bus.fetch_instr_pc = head;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, hand sequences for redirect
// and reset corners, then random traffic against a queue-based reference model.
module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: queue of entries, the PC, and one pending memory read.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_pend_pc;
    bit          m_pend;
    bit          m_started;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0001_4137;
        return (a * 32'h9E37_79B1) ^ NOP_INSTR;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc      = RESET_PC;
        m_pend    = 1'b0;
        m_pend_pc = '0;
        m_started = 1'b0;
    endtask

    // Called at posedge+1 with reset_n already high; ends at the next posedge+1.
    task automatic cycle(input logic j, input logic [31:0] ja, input logic rdy,
                         output logic o_req, output logic [31:0] o_addr,
                         output logic o_valid, output logic [63:0] o_data);
        logic        e_valid, e_req;
        logic [63:0] e_data;
        logic [31:0] rdata;
        rdata            = m_pend ? imem_word(m_pend_pc) : $urandom;
        bus.jaccept      = j;
        bus.jaddr        = ja;
        bus.decode_ready = rdy;
        bus.imem_rdata   = rdata;
        e_valid = (m_q.size() != 0);
        e_data  = e_valid ? m_q[0] : 64'h0;
        e_req   = m_started && !j && ((m_q.size() + int'(m_pend)) < int'(DEPTH));
        @(negedge clk);
        o_req   = bus.imem_req;
        o_addr  = bus.imem_addr;
        o_valid = bus.fetch_valid;
        o_data  = bus.fetch_instr_pc;
        check64("model_imem_req", 64'(o_req), 64'(e_req));
        check64("model_imem_addr", 64'(o_addr), 64'(m_pc));
        check64("model_fetch_valid", 64'(o_valid), 64'(e_valid));
        check64("model_fetch_instr_pc", o_data, e_data);
        m_started = 1'b1;
        if (j) begin
            m_q.delete();
            m_pend = 1'b0;
            m_pc   = {ja[31:2], 2'b00};
        end else begin
            if (e_valid && rdy) void'(m_q.pop_front());
            if (m_pend) m_q.push_back({rdata, m_pend_pc});
            if (e_req) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
            m_pend = e_req;
        end
        @(posedge clk);
        #1;
    endtask

    // Asserted at posedge+1; outputs must clear without waiting for a clock.
    task automatic do_reset();
        bus.jaccept      = 1'b0;
        bus.jaddr        = '0;
        bus.decode_ready = 1'b0;
        bus.imem_rdata   = $urandom;
        reset_n          = 1'b0;
        #1;
        check64("reset_imem_req", 64'(bus.imem_req), 64'h0);
        check64("reset_fetch_valid", 64'(bus.fetch_valid), 64'h0);
        check64("reset_fetch_instr_pc", bus.fetch_instr_pc, 64'h0);
        check64("reset_imem_addr", 64'(bus.imem_addr), 64'(RESET_PC));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic        r_req, r_valid;
        logic [31:0] r_addr;
        logic [63:0] r_data, exp_data;
        logic [31:0] first_pc;
        bit          seen;
        int          n, stale;

        // Cycle 0 is the first cycle after reset release; ready drops for 7..11.
        vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[4]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[5]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[6]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[7]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        vecs[8]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[9]  = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
        vecs[10] = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
        vecs[11] = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
        vecs[12] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10};
        vecs[13] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
        vecs[14] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
        vecs[15] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
        vecs[16] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};

        bus.jaccept      = 1'b0;
        bus.jaddr        = '0;
        bus.decode_ready = 1'b0;
        bus.imem_rdata   = '0;
        reset_n          = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 17; i++) begin
            cycle(1'b0, 32'h0, vecs[i].rdy, r_req, r_addr, r_valid, r_data);
            exp_data = vecs[i].exp_valid ? {imem_word(vecs[i].exp_pc), vecs[i].exp_pc} : 64'h0;
            check64($sformatf("vec%0d_req", i), 64'(r_req), 64'(vecs[i].exp_req));
            check64($sformatf("vec%0d_addr", i), 64'(r_addr), 64'(vecs[i].exp_addr));
            check64($sformatf("vec%0d_valid", i), 64'(r_valid), 64'(vecs[i].exp_valid));
            check64($sformatf("vec%0d_data", i), r_data, exp_data);
            if (i == 3) check64("first_fetch_word", r_data, 64'h0001_4137_0000_0000);
        end

        // Redirect while three entries are queued and a read is in flight.
        do_reset();
        n = 0;
        while (!(m_q.size() == 3 && m_pend) && n < 20) begin
            cycle(1'b0, 32'h0, 1'b0, r_req, r_addr, r_valid, r_data);
            n++;
        end
        check64("redir_setup_reached", 64'(n < 20), 64'h1);
        cycle(1'b1, 32'h103, 1'b1, r_req, r_addr, r_valid, r_data);
        check64("redir_jaccept_no_req", 64'(r_req), 64'h0);
        cycle(1'b0, 32'h0, 1'b1, r_req, r_addr, r_valid, r_data);
        check64("redir_flushed", 64'(r_valid), 64'h0);
        check64("redir_addr", 64'(r_addr), 64'h100);
        check64("redir_req", 64'(r_req), 64'h1);
        n = 0;
        r_valid = 1'b0;
        while (!r_valid && n < 8) begin
            cycle(1'b0, 32'h0, 1'b1, r_req, r_addr, r_valid, r_data);
            n++;
        end
        check64("redir_first_pc", 64'(r_data[31:0]), 64'h100);

        // Redirect coinciding with a pop, then a second redirect right behind it.
        repeat (3) cycle(1'b0, 32'h0, 1'b1, r_req, r_addr, r_valid, r_data);
        check64("b2b_pop_pending", 64'(r_valid), 64'h1);
        cycle(1'b1, 32'h200, 1'b1, r_req, r_addr, r_valid, r_data);
        cycle(1'b1, 32'h300, 1'b1, r_req, r_addr, r_valid, r_data);
        check64("b2b_flushed", 64'(r_valid), 64'h0);
        seen  = 1'b0;
        stale = 0;
        first_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 32'h0, 1'b1, r_req, r_addr, r_valid, r_data);
            if (i == 0) check64("b2b_addr", 64'(r_addr), 64'h300);
            if (r_valid) begin
                if (!seen) first_pc = r_data[31:0];
                seen = 1'b1;
                if (r_data[31:0] < 32'h300 || r_data[31:0] >= 32'h400) stale++;
            end
        end
        check64("b2b_first_pc", 64'(first_pc), 64'h300);
        check64("b2b_stale_count", 64'(stale), 64'h0);

        // Reset pulse while streaming with a read in flight.
        repeat (4) cycle(1'b0, 32'h0, 1'b1, r_req, r_addr, r_valid, r_data);
        check64("midreset_inflight", 64'(r_req), 64'h1);
        do_reset();
        n = 0;
        r_valid = 1'b0;
        while (!r_valid && n < 8) begin
            cycle(1'b0, 32'h0, 1'b1, r_req, r_addr, r_valid, r_data);
            n++;
        end
        check64("midreset_restart", r_data, {imem_word(RESET_PC), RESET_PC});

        // Random traffic: occasional redirects, bursty ready, rare reset pulses.
        for (int i = 0; i < 800; i++) begin
            int unsigned r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset();
            end else begin
                cycle(r < 12, (r < 6) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
                      ((i / 16) % 3 == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                      r_req, r_addr, r_valid, r_data);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
